// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder result stage.
package fp_pkg;

    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_ZERO    = 32'h0;

    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  flags;
    } fp_res_t;

endpackage

// File: rtl/fp_skid_buffer.sv
// Two-entry valid/ready buffer: main register M drives the outputs, skid register S
// absorbs one extra beat under backpressure so the producer can run at full rate.
import fp_pkg::*;

module fp_skid_buffer #(
    parameter type T = fp_res_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic m_valid;
    logic s_valid;
    T     m_data;
    T     s_data;
    logic in_xfer;
    logic drain;

    assign in_xfer   = in_valid & in_ready;
    assign drain     = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    // in_ready is a flop that always mirrors ~S.valid; S never fills while it is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            m_data   <= '0;
            s_data   <= '0;
            in_ready <= 1'b1;
        end else if (drain) begin
            if (s_valid) begin
                m_data   <= s_data;
                s_valid  <= 1'b0;
                in_ready <= 1'b1;
            end else if (in_xfer) begin
                m_data <= in_data;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (!m_valid) begin
                m_data  <= in_data;
                m_valid <= 1'b1;
            end else begin
                s_data   <= in_data;
                s_valid  <= 1'b1;
                in_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_add_result_stage.sv
// Registered IEEE-754 single post-processing stage behind the FP adder.
// Optional sticky flag register enabled by defining FP_STICKY_FLAGS_EN.
import fp_pkg::*;

module fp_add_result_stage #(
    parameter int SKID_EN_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_sum,
    input  logic        in_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
`ifdef FP_STICKY_FLAGS_EN
    ,
    input  logic        sticky_clr,
    output logic [2:0]  sticky_flags
`endif
);

    generate
        if (SKID_EN_DEPTH != 2) begin : g_bad_depth
            $error("fp_add_result_stage: SKID_EN_DEPTH must be 2");
        end
    endgenerate

    fp_res_t    cls;
    fp_res_t    buf_out;
    logic [7:0] exp_f;
    logic       frac_nz;

    assign exp_f   = in_sum[30:23];
    assign frac_nz = |in_sum[22:0];

    // NaN payloads collapse into infinity along with real overflow.
    always_comb begin
        cls.result = in_sum;
        cls.flags  = 3'b000;
        if (in_overflow || exp_f == FP_EXP_MAX) begin
            cls.result           = {in_sum[31], FP_EXP_MAX, 23'h0};
            cls.flags[FLAG_OVF]  = 1'b1;
        end else if (exp_f == 8'h00) begin
            cls.result           = FP_ZERO;
            cls.flags[FLAG_ZERO] = 1'b1;
            cls.flags[FLAG_UNF]  = frac_nz;
        end
    end

    fp_skid_buffer #(.T(fp_res_t)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (cls),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_result = buf_out.result;
    assign out_flags  = buf_out.flags;

`ifdef FP_STICKY_FLAGS_EN
    logic out_xfer;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 3'b000;
        end else if (sticky_clr || out_xfer) begin
            sticky_flags <= (sticky_clr ? 3'b000 : sticky_flags)
                          | (out_xfer ? out_flags : 3'b000);
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Randomized bench for fp_add_result_stage with a queue-based reference model.
module tb_fp_add_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sum;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic        sticky_clr;
    logic [2:0]  sticky_flags_w;

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 0;

    logic [34:0] q[$];
    logic [2:0]  st_model;

    fp_add_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags)
`ifdef FP_STICKY_FLAGS_EN
        ,
        .sticky_clr  (sticky_clr),
        .sticky_flags(sticky_flags_w)
`endif
    );

`ifndef FP_STICKY_FLAGS_EN
    assign sticky_flags_w = 3'b000;
`endif

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [34:0] classify(input logic [31:0] s, input logic o);
        logic [7:0] e;
        e = s[30:23];
        if (o || e == 8'd255)            return {s[31], 8'hFF, 23'h0, 3'b100};
        else if (e == 0 && s[22:0] != 0) return {32'h0, 3'b011};
        else if (e == 0)                 return {32'h0, 3'b001};
        else                             return {s, 3'b000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking && rst_n) begin
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                check("out_result", out_result, q[0][34:3]);
                check("out_flags", 32'(out_flags), 32'(q[0][2:0]));
            end
`ifdef FP_STICKY_FLAGS_EN
            check("sticky_flags", 32'(sticky_flags_w), 32'(st_model));
`endif
        end
    end

    // Drive one cycle, advance the model on the edge, return at edge+1.
    task automatic step(input logic v, input logic [31:0] s, input logic o,
                        input logic ordy, input logic clr);
        logic        ix, ox;
        logic [34:0] front;
        in_valid    = v;
        in_sum      = s;
        in_overflow = o;
        out_ready   = ordy;
        sticky_clr  = clr;
        ix    = v && (q.size() < 2);
        ox    = ordy && (q.size() > 0);
        front = (q.size() > 0) ? q[0] : 35'h0;
        @(posedge clk);
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(classify(s, o));
        if (clr) st_model = 3'b000;
        if (ox) st_model = st_model | front[2:0];
        #1;
    endtask

    function automatic logic [31:0] rand_sum();
        logic [31:0] s;
        int r;
        s = $urandom;
        r = $urandom_range(0, 7);
        if (r == 0) s[30:23] = 8'h00;
        else if (r == 1) s[30:23] = 8'hFF;
        if (r == 0 && $urandom_range(0, 1) == 0) s[22:0] = 23'h0;
        return s;
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; in_sum = 0; in_overflow = 0;
        out_ready = 0; sticky_clr = 0; st_model = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h1);
        check("rst out_result", out_result, 32'h0);
        check("rst out_flags", 32'(out_flags), 32'h0);
        check("rst sticky", 32'(sticky_flags_w), 32'h0);
        @(negedge clk);
        rst_n = 1;
        checking = 1;
        @(posedge clk);
        #1;

        step(1, 32'h4000_0000, 0, 1, 0);
        check("pass result", out_result, 32'h4000_0000);
        check("pass flags", 32'(out_flags), 32'h0);
        step(1, 32'hFF7F_FFFF, 1, 1, 0);
        check("ovf result", out_result, 32'hFF80_0000);
        check("ovf flags", 32'(out_flags), 32'h4);
        step(1, 32'h0000_0001, 0, 1, 0);
        check("flush result", out_result, 32'h0);
        check("flush flags", 32'(out_flags), 32'h3);
        step(1, 32'h8000_0000, 0, 1, 0);
        check("negzero result", out_result, 32'h0);
        check("negzero flags", 32'(out_flags), 32'h1);
        step(0, 0, 0, 1, 0);
        check("drained", 32'(out_valid), 32'h0);

        // Backpressure: 1.0, 2.0, 3.0 with the consumer stalled.
        step(1, 32'h3F80_0000, 0, 0, 0);
        step(1, 32'h4000_0000, 0, 0, 0);
        check("bp in_ready low", 32'(in_ready), 32'h0);
        step(1, 32'h4040_0000, 0, 0, 0);
        check("bp stall value", out_result, 32'h3F80_0000);
        check("bp still low", 32'(in_ready), 32'h0);
        step(1, 32'h4040_0000, 0, 1, 0);
        check("bp order 2", out_result, 32'h4000_0000);
        step(1, 32'h4040_0000, 0, 1, 0);
        check("bp order 3", out_result, 32'h4040_0000);
        check("bp valid 3", 32'(out_valid), 32'h1);
        step(0, 0, 0, 1, 0);
        check("bp empty", 32'(out_valid), 32'h0);

        // Reset mid-stream from FULL.
        step(1, 32'h3F80_0000, 0, 0, 0);
        step(1, 32'h4000_0000, 0, 0, 0);
        in_valid = 0;
        #2;
        checking = 0;
        rst_n = 0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'h0);
        check("midrst in_ready", 32'(in_ready), 32'h1);
        q.delete();
        st_model = 0;
        @(negedge clk);
        rst_n = 1;
        checking = 1;
        step(1, 32'h4120_0000, 0, 1, 0);
        check("post-rst valid", 32'(out_valid), 32'h1);
        check("post-rst result", out_result, 32'h4120_0000);
        step(0, 0, 0, 1, 1);

`ifdef FP_STICKY_FLAGS_EN
        step(1, 32'hFF7F_FFFF, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        check("sticky set wins", 32'(sticky_flags_w), 32'h4);
        step(0, 0, 0, 1, 1);
        check("sticky cleared", 32'(sticky_flags_w), 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_sum(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
